// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, one outstanding imem request, drives IF/ID.
// IF/ID updates one cycle after rvalid; stall freezes IF/ID and parks a returned word in holdBuf.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {START, FETCH, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] holdBuf;
  logic [31:0] pcPlus4;
  logic [31:0] redirectAligned;
  logic        deliver;
  logic [31:0] deliverWord;

  assign pcPlus4         = pc + 32'd4;
  assign redirectAligned = redirect_pc & ~32'h0000_0003;
  assign imem_addr       = pc;

  // A redirect in FETCH/HOLD always wins over delivering the current word.
  always_comb begin
    deliver     = 1'b0;
    deliverWord = imem_rdata;
    case (state)
      FETCH: deliver = !redirect_valid && imem_rvalid && !stall;
      HOLD: begin
        deliver     = !redirect_valid && !stall;
        deliverWord = holdBuf;
      end
      default: deliver = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= START;
      pc              <= RESET_PC;
      holdBuf         <= '0;
      imem_req        <= 1'b0;
      pc_out          <= '0;
      instruction_out <= '0;
      valid_out       <= 1'b0;
    end else begin
      if (flush) begin
        pc_out          <= '0;
        instruction_out <= '0;
        valid_out       <= 1'b0;
      end else if (!stall) begin
        pc_out          <= deliver ? pc : '0;
        instruction_out <= deliver ? deliverWord : '0;
        valid_out       <= deliver;
      end

      case (state)
        START: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (redirect_valid) begin
            pc <= redirectAligned;
            if (!imem_rvalid) begin
              state    <= DROP;
              imem_req <= 1'b0;
            end
          end else if (imem_rvalid) begin
            if (stall) begin
              holdBuf  <= imem_rdata;
              state    <= HOLD;
              imem_req <= 1'b0;
            end else begin
              pc <= pcPlus4;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc       <= redirectAligned;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (!stall) begin
            pc       <= pcPlus4;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        DROP: begin
          // The stale response must still be absorbed, so rvalid alone ends DROP.
          if (redirect_valid) pc <= redirectAligned;
          if (imem_rvalid) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= START;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, reset sequence, then random traffic vs a reference model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkAll(input string tag, input logic eReq, input logic [31:0] eAddr,
                        input logic [31:0] ePc, input logic [31:0] eIns, input logic eVld);
    chk({tag, "_req"},   32'(imem_req),  32'(eReq));
    chk({tag, "_addr"},  imem_addr,      eAddr);
    chk({tag, "_pcout"}, pc_out,         ePc);
    chk({tag, "_instr"}, instruction_out, eIns);
    chk({tag, "_valid"}, 32'(valid_out), 32'(eVld));
  endtask

  typedef struct {
    logic        st, fl, rv;
    logic [31:0] rd;
    logic        rdv;
    logic [31:0] rpc;
    logic        eReq;
    logic [31:0] eAddr, ePc, eIns;
    logic        eVld;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic fl, logic rv, logic [31:0] rd, logic rdv,
                              logic [31:0] rpc, logic eReq, logic [31:0] eAddr,
                              logic [31:0] ePc, logic [31:0] eIns, logic eVld);
    vec_t v;
    v.st = st; v.fl = fl; v.rv = rv; v.rd = rd; v.rdv = rdv; v.rpc = rpc;
    v.eReq = eReq; v.eAddr = eAddr; v.ePc = ePc; v.eIns = eIns; v.eVld = eVld;
    return v;
  endfunction

  // Reference model: fetch progress expressed as flags (started / word parked / response to discard).
  bit          mStarted, mHeld, mDiscard, mOutVld;
  logic [31:0] mPc, mHeldWord, mOutPc, mOutIns;

  task automatic modelReset();
    mStarted = 0; mHeld = 0; mDiscard = 0;
    mPc = RST_PC; mHeldWord = '0;
    mOutPc = '0; mOutIns = '0; mOutVld = 0;
  endtask

  task automatic modelStep(input bit st, input bit fl, input bit rv, input logic [31:0] rd,
                           input bit rdv, input logic [31:0] rpc);
    bit          del;
    logic [31:0] dPc, dW;
    del = 0; dPc = '0; dW = '0;
    if (!mStarted) begin
      mStarted = 1;
    end else if (rdv) begin
      mPc = {rpc[31:2], 2'b00};
      if (mHeld) mHeld = 0;
      else if (mDiscard) begin
        if (rv) mDiscard = 0;
      end else if (!rv) mDiscard = 1;
    end else if (mHeld) begin
      if (!st) begin
        del = 1; dPc = mPc; dW = mHeldWord; mPc = mPc + 32'd4; mHeld = 0;
      end
    end else if (mDiscard) begin
      if (rv) mDiscard = 0;
    end else if (rv) begin
      if (st) begin
        mHeld = 1; mHeldWord = rd;
      end else begin
        del = 1; dPc = mPc; dW = rd; mPc = mPc + 32'd4;
      end
    end
    if (fl) begin
      mOutPc = '0; mOutIns = '0; mOutVld = 0;
    end else if (!st) begin
      mOutPc = del ? dPc : '0; mOutIns = del ? dW : '0; mOutVld = del;
    end
  endtask

  bit          memBusy;
  int          memRem;
  logic [31:0] memAddr;

  initial begin
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,        1,32'h0040_0000,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,1,32'hFFBF_FFFF,0,32'h0,1,32'h0040_0004,32'h0040_0000,32'hFFBF_FFFF,1));
    tbl.push_back(mk(0,0,1,32'hFFBF_FFFB,0,32'h0,1,32'h0040_0008,32'h0040_0004,32'hFFBF_FFFB,1));
    tbl.push_back(mk(0,0,1,32'hFFBF_FFF7,0,32'h0,1,32'h0040_000C,32'h0040_0008,32'hFFBF_FFF7,1));
    tbl.push_back(mk(1,0,1,32'hFFBF_FFF3,0,32'h0,0,32'h0040_000C,32'h0040_0008,32'hFFBF_FFF7,1));
    tbl.push_back(mk(1,0,0,32'h0,0,32'h0,        0,32'h0040_000C,32'h0040_0008,32'hFFBF_FFF7,1));
    tbl.push_back(mk(1,0,0,32'h0,0,32'h0,        0,32'h0040_000C,32'h0040_0008,32'hFFBF_FFF7,1));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,        1,32'h0040_0010,32'h0040_000C,32'hFFBF_FFF3,1));
    tbl.push_back(mk(1,1,0,32'h0,0,32'h0,        1,32'h0040_0010,32'h0,32'h0,0));
    tbl.push_back(mk(1,0,0,32'h0,0,32'h0,        1,32'h0040_0010,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,1,32'hFFBF_FFEF,1,32'hFFFF_FFFF,1,32'hFFFF_FFFC,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,1,32'h0000_0003,0,32'h0,1,32'h0000_0000,32'hFFFF_FFFC,32'h0000_0003,1));
    tbl.push_back(mk(0,0,0,32'h0,1,32'h0040_0103,0,32'h0040_0100,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,32'h0,        0,32'h0040_0100,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,1,32'hDEAD_BEEF,0,32'h0,1,32'h0040_0100,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,1,32'h1111_1111,0,32'h0,1,32'h0040_0104,32'h0040_0100,32'h1111_1111,1));
    tbl.push_back(mk(1,0,1,32'h2222_2222,0,32'h0,0,32'h0040_0104,32'h0040_0100,32'h1111_1111,1));
    tbl.push_back(mk(1,0,0,32'h0,1,32'h0050_0000,1,32'h0050_0000,32'h0040_0100,32'h1111_1111,1));
    tbl.push_back(mk(0,0,1,32'h3333_3333,0,32'h0,1,32'h0050_0004,32'h0050_0000,32'h3333_3333,1));
    tbl.push_back(mk(0,0,0,32'h0,1,32'h0060_0000,0,32'h0060_0000,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0,32'h0,1,32'h0070_0006,0,32'h0070_0004,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,1,32'hAAAA_AAAA,0,32'h0,1,32'h0070_0004,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,1,32'h4444_4444,0,32'h0,1,32'h0070_0008,32'h0070_0004,32'h4444_4444,1));

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chkAll("reset", 1'b0, RST_PC, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    chkAll("start", 1'b0, RST_PC, 32'h0, 32'h0, 1'b0);

    foreach (tbl[i]) begin
      stall = tbl[i].st; flush = tbl[i].fl;
      imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd;
      redirect_valid = tbl[i].rdv; redirect_pc = tbl[i].rpc;
      @(posedge clk);
      #1;
      chkAll($sformatf("row%0d", i), tbl[i].eReq, tbl[i].eAddr, tbl[i].ePc, tbl[i].eIns, tbl[i].eVld);
    end

    // Asynchronous reset in the middle of a cycle, then rvalid and redirect during START.
    stall = 0; flush = 0; redirect_valid = 0; imem_rvalid = 0;
    #2 rst = 1'b0;
    #1;
    chkAll("async_rst", 1'b0, RST_PC, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    imem_rvalid = 1; imem_rdata = 32'hCAFE_BABE;
    redirect_valid = 1; redirect_pc = 32'h1234_5678;
    @(posedge clk);
    #1;
    chkAll("start_ignore", 1'b1, RST_PC, 32'h0, 32'h0, 1'b0);
    redirect_valid = 0; imem_rvalid = 1; imem_rdata = 32'hFFBF_FFFF;
    @(posedge clk);
    #1;
    chkAll("restart", 1'b1, 32'h0040_0004, 32'h0040_0000, 32'hFFBF_FFFF, 1'b1);

    // Random traffic with variable-latency memory.
    imem_rvalid = 0; rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();
    memBusy = 0; memRem = 0; memAddr = '0;
    for (int c = 0; c < 3000; c++) begin
      bit          rv, st, fl, rdv;
      logic [31:0] rd, rpc;
      chkAll("rnd", 1'(mStarted && !mHeld && !mDiscard), mPc, mOutPc, mOutIns, mOutVld);
      if (!memBusy && imem_req) begin
        memBusy = 1; memAddr = imem_addr; memRem = $urandom_range(0, 3);
      end
      rv  = memBusy && (memRem == 0);
      rd  = rv ? ~memAddr : $urandom;
      st  = ($urandom_range(0, 99) < 25);
      fl  = ($urandom_range(0, 99) < 8);
      rdv = ($urandom_range(0, 99) < 10);
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      stall = st; flush = fl; imem_rvalid = rv; imem_rdata = rd;
      redirect_valid = rdv; redirect_pc = rpc;
      modelStep(st, fl, rv, rd, rdv, rpc);
      @(posedge clk);
      #1;
      if (rv) memBusy = 0;
      else if (memBusy) memRem--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter and fetches one instruction at a time over a single-outstanding request/response instruction-memory port. It drives the IF/ID pipeline register (`pc_out`, `instruction_out`, `valid_out`) consumed directly by the decode stage. It honours stall, flush and branch/jump redirects from the hazard and branch-resolution logic.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC fetched first after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `stall`  in  1  hold the IF/ID register and do not deliver a new instruction.
- `flush`  in  1  load a bubble into the IF/ID register.
- `redirect_valid`  in  1  change fetch PC (taken branch, j, jal, jr).
- `redirect_pc`  in  32  new PC; bits [1:0] forced to 0.
- `imem_req`  out  1  fetch request, level-held until response.
- `imem_addr`  out  32  fetch address, equals internal `pc`.
- `imem_rvalid`  in  1  response valid; may assert in the same cycle as `imem_req` (combinational memory) or any later cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `pc_out`  out  32  IF/ID: PC of delivered instruction.
- `instruction_out`  out  32  IF/ID: instruction word; bubble = 32'h0000_0000 (sll $0 nop).
- `valid_out`  out  1  IF/ID: instruction is real, not a bubble.

## Operation
- Internal state: `pc` (32 b), `hold_buf` (32 b), FSM state.
- START: entered on reset.
  - `imem_req`=0; `imem_rvalid` ignored.
  - Next cycle → FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`; address held stable until `imem_rvalid`.
  - rvalid & !stall: IF/ID ← {`pc`, rdata, 1}; `pc` ← `pc`+4; stay FETCH.
  - rvalid & stall: `hold_buf` ← rdata; → HOLD.
  - no rvalid & !stall: IF/ID ← bubble {0,0,0}.
- HOLD: `imem_req`=0.
  - !stall: IF/ID ← {`pc`, `hold_buf`, 1}; `pc` ← `pc`+4; → FETCH.
- DROP: `imem_req`=0; waits for the stale response.
  - rvalid: data discarded; → FETCH.
  - !stall: IF/ID ← bubble.
- Redirect (any state except START): `pc` ← {redirect_pc[31:2],2'b00}; no instruction delivered that cycle.
  - FETCH without rvalid → DROP.
  - FETCH with rvalid → FETCH; data discarded.
  - HOLD → FETCH; `hold_buf` discarded.
  - DROP → stays DROP; new PC replaces the pending one.
- Redirect in START: ignored.
- IF/ID priority: flush > stall > load/bubble. A flush forces a bubble regardless of stall.
- Flush never alters `pc`, FSM state or `hold_buf`. A squashed fetch requires `redirect_valid`.
- Fetch-side priority: rst > redirect > normal.
- `pc`+4 is modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.

## Timing
- Reset values:
  - `pc`=RESET_PC, state START, `hold_buf`=0.
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `pc_out`=0, `instruction_out`=0, `valid_out`=0.
- Reset mid-operation clears everything asynchronously; any in-flight response is ignored via START.
- First `imem_req` is asserted in the first cycle after rst deasserts plus one (START cycle).
- Latency: rvalid in cycle N (with !stall) → IF/ID visible in cycle N+1; next request presented in N+1.
- Combinational memory: one instruction per cycle sustained.
- Redirect in cycle N: request to the new PC no earlier than N+1; DROP adds cycles until the stale rvalid.
- Stall is sampled every cycle. IF/ID outputs are constant for every stalled cycle unless flush is asserted.

## Test plan
- Reset, combinational imem returning `addr` XOR 32'hFFFF_FFFF, no stall → first req at RESET_PC two cycles after release; `pc_out` = 0040_0000, 0040_0004, 0040_0008 on consecutive cycles with `valid_out`=1.
- Stall for 3 cycles while rvalid arrives → IF/ID frozen; `imem_req`=0 during HOLD; held word delivered on release; next req at `pc`+4.
- Memory latency 3 cycles, redirect_pc=32'h0040_0103 asserted one cycle after req → DROP; stale data never reaches IF/ID; next req addr 0040_0100.
- flush together with stall while IF/ID holds a valid instruction → next cycle `instruction_out`=0, `valid_out`=0, `pc_out`=0; `pc` unchanged.
- redirect_pc=32'hFFFF_FFFC, no stall → delivered pc FFFF_FFFC, next req address 0000_0000.
- rst pulled low mid-request → outputs zero immediately (asynchronous); rvalid asserted in START ignored; fetch restarts at RESET_PC.
